// File: rtl/debounce_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and counter sizing helper.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing an asynchronous level into clock domain c.
module sync2 (
    input  logic c,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1;

    always_ff @(posedge c) begin
        if (reset) begin
            sync1 <= 1'b0;
            q     <= 1'b0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchroniser, stability-count FSM, registered level/press/busy.
// Define BUTTON_DEBOUNCER_RELEASE_EN to add the release pulse port, named `released`
// because `release` is a reserved word.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic c,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic busy
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    ,
    output logic released
`endif
);

    localparam int unsigned CNT_W = clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             busy_nxt;
    logic             sync2_q;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic             released_nxt;
`endif

    sync2 u_sync (
        .c     (c),
        .reset (reset),
        .d     (btn_raw),
        .q     (sync2_q)
    );

    // State register
    always_ff @(posedge c) begin
        if (reset) begin
            state <= IDLE_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: any disagreeing sample in a WAIT state falls back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE_LO: if (sync2_q) state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (!sync2_q) begin
                    state_nxt = IDLE_LO;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE_HI;
                end
            end
            IDLE_HI: if (!sync2_q) state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (sync2_q) begin
                    state_nxt = IDLE_HI;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE_LO;
                end
            end
            default: state_nxt = IDLE_LO;
        endcase
    end

    // Output and counter next values; the counter is cleared on acceptance so it never wraps
    always_comb begin
        cnt_nxt      = cnt;
        level_nxt    = level;
        press_nxt    = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        released_nxt = 1'b0;
`endif
        case (state)
            IDLE_LO: if (sync2_q) cnt_nxt = CNT_ONE;
            WAIT_HI: begin
                if (!sync2_q) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE_HI: if (!sync2_q) cnt_nxt = CNT_ONE;
            WAIT_LO: begin
                if (sync2_q) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt      = '0;
                    level_nxt    = 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
                    released_nxt = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: cnt_nxt = '0;
        endcase
        busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
    end

    // Registered outputs and stability counter
    always_ff @(posedge c) begin
        if (reset) begin
            cnt      <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            busy     <= 1'b0;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            released <= 1'b0;
`endif
        end else begin
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            press    <= press_nxt;
            busy     <= busy_nxt;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            released <= released_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: fixed vector table plus a reference-model scoreboard.
module tb_button_debouncer;

    localparam int unsigned S = 4;

    logic c = 1'b0;
    logic reset;
    logic btn_raw;
    logic level;
    logic press;
    logic busy;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
    logic released;
`endif

    always #5 c = ~c;

    button_debouncer #(.STABLE_CYCLES(S)) dut (
        .c       (c),
        .reset   (reset),
        .btn_raw (btn_raw),
        .level   (level),
        .press   (press),
        .busy    (busy)
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        ,
        .released(released)
`endif
    );

    typedef struct {
        logic level;
        logic press;
        logic busy;
        logic rel;
    } exp_t;

    typedef struct {
        logic btn;
        logic level;
        logic press;
        logic busy;
        logic rel;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        m_out;
    logic        m_s1 = 1'b0;
    logic        m_s2 = 1'b0;
    logic        m_level = 1'b0;
    int unsigned m_run = 0;
    int unsigned n_press = 0;
    logic [2:0]  down_cnt = 3'd0;
    logic        lv, pr, bs, rl;
    vec_t        vec[17];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive synchronised samples that disagree with the level
    task automatic model_edge(input logic r, input logic b);
        logic sample;
        sample      = m_s2;
        m_out.press = 1'b0;
        m_out.rel   = 1'b0;
        if (r) begin
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            m_level = 1'b0;
            m_run   = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = b;
            if (sample != m_level) begin
                m_run++;
                if (m_run == S + 1) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    if (m_level) m_out.press = 1'b1;
                    else         m_out.rel   = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        m_out.level = m_level;
        m_out.busy  = (m_run != 0);
    endtask

    // One clock: drive inputs, push model expectation, sample #1 after the edge, pop and compare
    task automatic step(input logic r, input logic b, input bit use_sb);
        exp_t e;
        reset   = r;
        btn_raw = b;
        @(posedge c);
        model_edge(r, b);
        sb_q.push_back(m_out);
        #1;
        lv = level;
        pr = press;
        bs = busy;
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
        rl = released;
`else
        rl = 1'b0;
`endif
        if (pr) begin
            n_press++;
            down_cnt = down_cnt + 3'd1;
        end
        e = sb_q.pop_front();
        if (use_sb) begin
            check1("sb_level", lv, e.level);
            check1("sb_press", pr, e.press);
            check1("sb_busy",  bs, e.busy);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            check1("sb_release", rl, e.rel);
`endif
        end
    endtask

    initial begin
        int first_press;
        int p0;
        logic b;
        int hold;

        // Clean press then release, expectations per edge (btn, level, press, busy, release)
        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        reset   = 1'b1;
        btn_raw = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check1("reset_level", lv, 1'b0);
        check1("reset_press", pr, 1'b0);
        check1("reset_busy",  bs, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 17; i++) begin
            step(1'b0, vec[i].btn, 1'b0);
            check1($sformatf("tbl%0d_level", i), lv, vec[i].level);
            check1($sformatf("tbl%0d_press", i), pr, vec[i].press);
            check1($sformatf("tbl%0d_busy", i),  bs, vec[i].busy);
`ifdef BUTTON_DEBOUNCER_RELEASE_EN
            check1($sformatf("tbl%0d_release", i), rl, vec[i].rel);
`endif
        end

        // Reset while the button is held and level is high
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
        check1("held_level_before_reset", lv, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check1("rst_held_level", lv, 1'b0);
            check1("rst_held_press", pr, 1'b0);
            check1("rst_held_busy",  bs, 1'b0);
        end
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check1($sformatf("post_rst_press_e%0d", i), pr, (i == S + 3) ? 1'b1 : 1'b0);
        end

        // Bounce before a press: one pulse, after five stable synchronised samples
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        p0          = int'(n_press);
        first_press = -1;
        for (int i = 0; i < 20; i++) begin
            case (i)
                1, 4:    b = 1'b0;
                default: b = 1'b1;
            endcase
            step(1'b0, b, 1'b1);
            if (pr && first_press < 0) first_press = i;
        end
        check_int("bounce_press_count", int'(n_press) - p0, 1);
        check_int("bounce_press_edge", first_press, 11);

        // Reset in the middle of a WAIT_HI qualification
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        p0 = int'(n_press);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        check1("midwait_busy_before", bs, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check1("midwait_busy", bs, 1'b0);
        check1("midwait_level", lv, 1'b0);
        check1("midwait_press", pr, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        check_int("midwait_no_press", int'(n_press) - p0, 0);

        // Downstream 3-bit counter fed by press: nine presses wrap to 1
        down_cnt = 3'd0;
        p0       = int'(n_press);
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
        end
        check_int("counter_presses", int'(n_press) - p0, 9);
        check_int("counter_value", int'(down_cnt), 1);

        // Random held levels with occasional resets, checked against the model
        b = 1'b0;
        for (int k = 0; k < 80; k++) begin
            b    = ($urandom_range(0, 2) != 0) ? ~b : b;
            hold = int'($urandom_range(1, 9));
            for (int i = 0; i < hold; i++) begin
                step(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, b, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Cleans a mechanical push-button input and produces the single-cycle event pulse that drives the 3-bit `counter` stage's count event. The block sits directly upstream of `counter`. It synchronises the asynchronous raw button into clock domain `c`, rejects bounce with a stability-count FSM, and emits a debounced level plus a one-cycle press pulse per accepted 0→1 transition.

## Interface
- `STABLE_CYCLES`, default 4: the raw input must hold a new level for STABLE_CYCLES+1 consecutive samples before it is accepted. Legal range is 1..255.
- `c`  in  1: clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset, sampled on posedge `c`.
- `btn_raw`  in  1: asynchronous, bouncy button level.
- `level`  out  1: debounced button level. Resets to 0.
- `press`  out  1: one-cycle pulse on each accepted 0→1 of `level`. Resets to 0.
- `release`  out  1: one-cycle pulse on each accepted 1→0 of `level`. Present only under `BUTTON_DEBOUNCER_RELEASE_EN`. Resets to 0.
- `busy`  out  1: high while the FSM is in WAIT_HI or WAIT_LO. Resets to 0.

## Operation
- **Synchroniser:** two flops, `sync1 <= btn_raw` and `sync2 <= sync1`. Both reset to 0. The FSM sees only `sync2`.
- **Stability counter:** `cnt`, width is ceil(log2(STABLE_CYCLES+1)). Resets to 0.
- **FSM states:** IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Reset state is IDLE_LO.
  - IDLE_LO: if `sync2`=1 → WAIT_HI, `cnt`<=1.
  - WAIT_HI: if `sync2`=0 → IDLE_LO, `cnt`<=0 (bounce rejected, no output). Else if `cnt`==STABLE_CYCLES → IDLE_HI, `level`<=1, `press`<=1. Else `cnt`<=`cnt`+1.
  - IDLE_HI: if `sync2`=0 → WAIT_LO, `cnt`<=1.
  - WAIT_LO: mirror of WAIT_HI. On acceptance go to IDLE_LO, `level`<=0, and pulse `release` if the macro is enabled.
- `press` and `release` are registered. They are cleared on the cycle after being set. They can never both be high.
- **Counter width:** `cnt` never exceeds STABLE_CYCLES and never wraps.
- **Reset mid-operation:** reset aborts any WAIT state and emits no pulse. `level` returns to 0 even if the button is held. If `btn_raw` stays high after reset deasserts, the block runs a full debounce and then emits `press`.
- **Glitch handling:** a single-sample glitch during a WAIT state returns the FSM to its IDLE state, and the count restarts from zero on the next qualifying sample.

## Timing
- Let edge k be the first edge at which `btn_raw`=1 is sampled.
- If `btn_raw` is high at edges k..k+STABLE_CYCLES, then `level` and `press` go high after edge k+2+STABLE_CYCLES.
- `press` stays high for exactly one cycle.
- The release path has the same latency.
- Total latency is 2 cycles of synchroniser plus STABLE_CYCLES+1 cycles of qualification.
- `busy` rises after edge k+2. It falls together with the `level` update or the bounce rejection.
- Minimum press-to-press interval is 2·(STABLE_CYCLES+1) cycles.

## Configuration
- Macro: `BUTTON_DEBOUNCER_RELEASE_EN`.
- **Defined:** the `release` port exists and pulses one cycle on each accepted 1→0.
- **Undefined:** the `release` port and its register are omitted. WAIT_LO→IDLE_LO only clears `level`. All other behaviour is identical.

## Structure
- **Package `debounce_pkg`:**
  - 2-bit state encodings: IDLE_LO=0, WAIT_HI=1, IDLE_HI=2, WAIT_LO=3.
  - A clog2 width function used to size `cnt`.
- **Sub-module `sync2`:** a two-flop synchroniser with ports `c`, `reset`, `d`, `q`, instantiated once. It is reused by later input blocks.
- **Top level:** holds the FSM, counter and output registers.

## Test plan
- **Reset with button held:** `reset`=1 for 3 cycles with `btn_raw`=1 → `level`, `press` and `busy` are 0 throughout. After release of `reset`, `press` pulses once, STABLE_CYCLES+3 edges later (7 with the default).
- **Clean press, STABLE_CYCLES=4:** `btn_raw` goes 0→1 at edge 0 and is held → `busy`=1 after edge 2, `level`=1 and `press`=1 after edge 6, `press`=0 after edge 7.
- **Bounce:** `btn_raw` pattern 1,0,1,1,0,1 on edges 0-5, then 1 held → no `press` until 5 stable samples follow. Exactly one `press` pulse in total.
- **Release:** with `level`=1, drop `btn_raw` at edge 20 → `level`=0 after edge 26. With the macro defined, `release` pulses exactly one cycle. Without it, no `release` port exists.
- **Reset mid-WAIT:** assert `reset` at edge 4 of a clean press → no `press`, FSM in IDLE_LO, `cnt`=0, `busy`=0 after edge 4.
- **Drive counter:** connect `press` as the count event and make 9 clean presses → the downstream 3-bit count wraps to 1.
